// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: gap, timed one-hot mole, hit/miss/timeout, score.
// Optional: MOLE_STREAK_SPEEDUP_EN shortens the window as the hit streak grows.
module mole_round_controller #(
    parameter int NUM_MOLES  = 3,
    parameter int SCORE_W    = 8,
    parameter int CNT_W      = 28,
    parameter int GAP_CYCLES = 150000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game,
    input  logic [CNT_W-1:0]     speed,
    input  logic [NUM_MOLES-1:0] button,
    output logic [NUM_MOLES-1:0] moles,
    output logic [SCORE_W-1:0]   score,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHOW
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_MOLES-1:0] ONE = {{(NUM_MOLES-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [NUM_MOLES-1:0] btn_prev_q;
    logic [NUM_MOLES-1:0] rise_q, rise_d;
    logic [NUM_MOLES-1:0] moles_d;
    logic [SCORE_W-1:0]   score_d;
    logic                 hit_d, miss_d, timeout_d;

    logic [NUM_MOLES-1:0] rise;
    logic [7:0]           mole_idx;
    logic [CNT_W-1:0]     win;
    logic [CNT_W-1:0]     win_load;
    logic                 hit_now, wrong_now;

`ifdef MOLE_STREAK_SPEEDUP_EN
    logic [3:0] streak_q, streak_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            counter_q     <= '0;
            lfsr_q        <= 8'h01;
            btn_prev_q    <= '0;
            rise_q        <= '0;
            moles         <= '0;
            score         <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
`ifdef MOLE_STREAK_SPEEDUP_EN
            streak_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            lfsr_q        <= lfsr_d;
            btn_prev_q    <= button;
            rise_q        <= rise_d;
            moles         <= moles_d;
            score         <= score_d;
            hit_pulse     <= hit_d;
            miss_pulse    <= miss_d;
            timeout_pulse <= timeout_d;
`ifdef MOLE_STREAK_SPEEDUP_EN
            streak_q      <= streak_d;
`endif
        end
    end

    // Rises are registered once and only while a mole is up, so a press
    // carried over from the gap never reaches the scoring logic.
    always_comb begin
        rise      = button & ~btn_prev_q;
        hit_now   = |(rise_q & moles);
        wrong_now = |(rise_q & ~moles);
        mole_idx  = 8'(32'(lfsr_q) % NUM_MOLES);
`ifdef MOLE_STREAK_SPEEDUP_EN
        win = speed >> streak_q[3:2];
`else
        win = speed;
`endif
        if (win == '0) begin
            win = CNT_W'(1);
        end
        win_load = win - CNT_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        lfsr_d    = lfsr_q;
        moles_d   = moles;
        score_d   = score;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;
        rise_d    = (state_q == SHOW) ? rise : '0;
`ifdef MOLE_STREAK_SPEEDUP_EN
        streak_d  = streak_q;
`endif
        if (!game) begin
            state_d   = IDLE;
            counter_d = '0;
            lfsr_d    = 8'h01;
            moles_d   = '0;
            score_d   = '0;
            rise_d    = '0;
`ifdef MOLE_STREAK_SPEEDUP_EN
            streak_d  = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = GAP;
                    counter_d = GAP_LOAD;
                    moles_d   = '0;
                end
                GAP: begin
                    moles_d = '0;
                    if (counter_q == '0) begin
                        state_d   = SHOW;
                        moles_d   = ONE << mole_idx;
                        counter_d = win_load;
                        lfsr_d    = {lfsr_q[6:0],
                                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    end else begin
                        counter_d = counter_q - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (hit_now) begin
                        if (score != '1) begin
                            score_d = score + SCORE_W'(1);
                        end
                        hit_d     = 1'b1;
                        moles_d   = '0;
                        state_d   = GAP;
                        counter_d = GAP_LOAD;
`ifdef MOLE_STREAK_SPEEDUP_EN
                        if (streak_q != 4'hF) begin
                            streak_d = streak_q + 4'd1;
                        end
`endif
                    end else begin
                        if (wrong_now) begin
                            miss_d = 1'b1;
                            if (score != '0) begin
                                score_d = score - SCORE_W'(1);
                            end
`ifdef MOLE_STREAK_SPEEDUP_EN
                            streak_d = '0;
`endif
                        end
                        if (counter_q == '0) begin
                            timeout_d = 1'b1;
                            moles_d   = '0;
                            state_d   = GAP;
                            counter_d = GAP_LOAD;
`ifdef MOLE_STREAK_SPEEDUP_EN
                            streak_d  = '0;
`endif
                        end else begin
                            counter_d = counter_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    moles_d = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed bench for mole_round_controller (3 moles, gap 4, window 6).
// A second instance with a 2-bit score covers saturation.
module tb_mole_round_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        game;
    logic [27:0] speed;
    logic [2:0]  button;
    logic [2:0]  moles_a, moles_b;
    logic [7:0]  score_a;
    logic [1:0]  score_b;
    logic        hit_a, miss_a, tmo_a;
    logic        hit_b, miss_b, tmo_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mole_round_controller #(
        .NUM_MOLES(3), .SCORE_W(8), .CNT_W(28), .GAP_CYCLES(4)
    ) dut_a (
        .clock(clock), .reset(reset), .game(game), .speed(speed),
        .button(button), .moles(moles_a), .score(score_a),
        .hit_pulse(hit_a), .miss_pulse(miss_a), .timeout_pulse(tmo_a)
    );

    mole_round_controller #(
        .NUM_MOLES(3), .SCORE_W(2), .CNT_W(28), .GAP_CYCLES(4)
    ) dut_b (
        .clock(clock), .reset(reset), .game(game), .speed(speed),
        .button(button), .moles(moles_b), .score(score_b),
        .hit_pulse(hit_b), .miss_pulse(miss_b), .timeout_pulse(tmo_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        game   = 1'b0;
        button = 3'b000;
        speed  = 28'd6;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_game();
        do_reset();
        game = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (moles_a !== 3'b000 || score_a !== 8'd0 ||
            {hit_a, miss_a, tmo_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_a: moles=%b score=%0d pulses=%b, want 000 0 000",
                     moles_a, score_a, {hit_a, miss_a, tmo_a});
        end
        n_checks++;
        if (moles_b !== 3'b000 || score_b !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_b: moles=%b score=%0d, want 000 0", moles_b, score_b);
        end
    endtask

    task automatic test_start();
        do_reset();
        game = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (moles_a !== 3'b000) begin
                n_fail++;
                $display("FAIL start_dark edge %0d: moles=%b, want 000", i, moles_a);
            end
        end
        tick();
        n_checks++;
        if (moles_a !== 3'b010) begin
            n_fail++;
            $display("FAIL start_first_mole: moles=%b, want 010", moles_a);
        end
    endtask

    task automatic test_timeout();
        start_game();
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (moles_a !== 3'b010 || tmo_a !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_lit %0d: moles=%b tmo=%b, want 010 0",
                         i, moles_a, tmo_a);
            end
        end
        tick();
        n_checks++;
        if (moles_a !== 3'b000 || tmo_a !== 1'b1 || score_a !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout_pulse: moles=%b tmo=%b score=%0d, want 000 1 0",
                     moles_a, tmo_a, score_a);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (moles_a !== 3'b000 || tmo_a !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_gap %0d: moles=%b tmo=%b, want 000 0",
                         i, moles_a, tmo_a);
            end
        end
        tick();
        n_checks++;
        if (moles_a !== 3'b100) begin
            n_fail++;
            $display("FAIL second_mole: moles=%b, want 100", moles_a);
        end
        repeat (10) tick();
        n_checks++;
        if (moles_a !== 3'b010) begin
            n_fail++;
            $display("FAIL third_mole: moles=%b, want 010", moles_a);
        end
    endtask

    task automatic test_hit();
        start_game();
        button = 3'b010;
        tick();
        n_checks++;
        if (moles_a !== 3'b010 || hit_a !== 1'b0 || score_a !== 8'd0) begin
            n_fail++;
            $display("FAIL hit_latency: moles=%b hit=%b score=%0d, want 010 0 0",
                     moles_a, hit_a, score_a);
        end
        tick();
        n_checks++;
        if (moles_a !== 3'b000 || hit_a !== 1'b1 || score_a !== 8'd1) begin
            n_fail++;
            $display("FAIL hit: moles=%b hit=%b score=%0d, want 000 1 1",
                     moles_a, hit_a, score_a);
        end
        repeat (4) tick();
        n_checks++;
        if (moles_a !== 3'b100) begin
            n_fail++;
            $display("FAIL hit_next_mole: moles=%b, want 100", moles_a);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (score_a !== 8'd1 || hit_a !== 1'b0 || miss_a !== 1'b0) begin
                n_fail++;
                $display("FAIL held_button %0d: score=%0d hit=%b miss=%b, want 1 0 0",
                         i, score_a, hit_a, miss_a);
            end
        end
        button = 3'b000;
    endtask

    task automatic test_miss();
        start_game();
        button = 3'b010;
        tick();
        tick();
        button = 3'b000;
        repeat (4) tick();
        button = 3'b001;
        tick();
        button = 3'b011;
        tick();
        n_checks++;
        if (score_a !== 8'd0 || miss_a !== 1'b1 || moles_a !== 3'b100) begin
            n_fail++;
            $display("FAIL miss_dec: score=%0d miss=%b moles=%b, want 0 1 100",
                     score_a, miss_a, moles_a);
        end
        button = 3'b000;
        tick();
        n_checks++;
        if (score_a !== 8'd0 || miss_a !== 1'b1 || moles_a !== 3'b100) begin
            n_fail++;
            $display("FAIL miss_floor: score=%0d miss=%b moles=%b, want 0 1 100",
                     score_a, miss_a, moles_a);
        end
        button = 3'b101;
        tick();
        n_checks++;
        if (miss_a !== 1'b0 || hit_a !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_quiet: miss=%b hit=%b, want 0 0", miss_a, hit_a);
        end
        tick();
        n_checks++;
        if (hit_a !== 1'b1 || miss_a !== 1'b0 || score_a !== 8'd1 ||
            moles_a !== 3'b000) begin
            n_fail++;
            $display("FAIL hit_beats_miss: hit=%b miss=%b score=%0d moles=%b, want 1 0 1 000",
                     hit_a, miss_a, score_a, moles_a);
        end
        button = 3'b000;
    endtask

    task automatic test_saturation();
        logic [7:0] l;
        logic [2:0] exp_m;
        logic [1:0] exp_b;
        start_game();
        l = 8'h01;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && moles_a === 3'b000; i++) tick();
            exp_m = 3'b001 << (l % 3);
            n_checks++;
            if (moles_a !== exp_m) begin
                n_fail++;
                $display("FAIL sat_mole %0d: moles=%b, want %b", k, moles_a, exp_m);
            end
            button = exp_m;
            tick();
            button = 3'b000;
            tick();
            exp_b = (k >= 2) ? 2'd3 : 2'(k + 1);
            n_checks++;
            if (hit_b !== 1'b1 || score_b !== exp_b || score_a !== 8'(k + 1)) begin
                n_fail++;
                $display("FAIL sat_hit %0d: hit=%b score_b=%0d score_a=%0d, want 1 %0d %0d",
                         k, hit_b, score_b, score_a, exp_b, k + 1);
            end
            l = lfsr_next(l);
        end
    endtask

    task automatic test_abort();
        start_game();
        button = 3'b010;
        tick();
        button = 3'b000;
        repeat (5) tick();
        n_checks++;
        if (moles_a !== 3'b100 || score_a !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_setup: moles=%b score=%0d, want 100 1", moles_a, score_a);
        end
        game = 1'b0;
        tick();
        n_checks++;
        if (moles_a !== 3'b000 || score_a !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_game: moles=%b score=%0d, want 000 0", moles_a, score_a);
        end
        game = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (moles_a !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_regap: moles=%b, want 000", moles_a);
        end
        tick();
        n_checks++;
        if (moles_a !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_restart: moles=%b, want 010", moles_a);
        end
        button = 3'b010;
        tick();
        button = 3'b000;
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (moles_a !== 3'b000 || score_a !== 8'd0 || hit_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_gap: moles=%b score=%0d hit=%b, want 000 0 0",
                     moles_a, score_a, hit_a);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (moles_a !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_restart: moles=%b, want 010", moles_a);
        end
    endtask

    initial begin
        reset  = 1'b1;
        game   = 1'b0;
        button = 3'b000;
        speed  = 28'd6;
        test_reset();
        test_start();
        test_timeout();
        test_hit();
        test_miss();
        test_saturation();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
